// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable divider with duty control and tick.
// Define CLKDIV_PHASE_OUT_EN to expose the registered counter as `phase`.
module clock_divider_prog #(
    parameter int CNT_WIDTH      = 32,
    parameter int PERIOD_DEFAULT = 50000,
    parameter int HIGH_DEFAULT   = 25000
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period_in,
    input  logic [CNT_WIDTH-1:0] high_in,
    input  logic                 load,
    output logic                 load_ack,
    output logic                 divclk,
    output logic                 tick
`ifdef CLKDIV_PHASE_OUT_EN
    ,
    output logic [CNT_WIDTH-1:0] phase
`endif
);

    localparam logic [CNT_WIDTH-1:0] PER_RST  = CNT_WIDTH'(PERIOD_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] HIGH_RST = CNT_WIDTH'(HIGH_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] MIN_PER  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] per_a;
    logic [CNT_WIDTH-1:0] high_a;
    logic [CNT_WIDTH-1:0] per_s;
    logic [CNT_WIDTH-1:0] high_s;
    logic                 pending;

    logic [CNT_WIDTH-1:0] per_c;
    logic [CNT_WIDTH-1:0] high_c;
    logic                 wrap;
    logic                 apply;

    always_comb begin
        per_c  = (period_in < MIN_PER) ? MIN_PER : period_in;
        high_c = (high_in > per_c) ? per_c : high_in;
    end

    // Settings only change at a period boundary or while idle: no runt pulses.
    always_comb begin
        wrap  = en && (cnt == per_a - ONE);
        apply = !en || wrap;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt      <= '0;
            per_a    <= PER_RST;
            high_a   <= HIGH_RST;
            per_s    <= PER_RST;
            high_s   <= HIGH_RST;
            pending  <= 1'b0;
            divclk   <= 1'b0;
            tick     <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (en) begin
                divclk <= (cnt < high_a);
                tick   <= wrap;
                cnt    <= wrap ? '0 : cnt + ONE;
            end else begin
                divclk <= 1'b0;
                tick   <= 1'b0;
                cnt    <= '0;
            end
            if (apply && load) begin
                per_a    <= per_c;
                high_a   <= high_c;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (apply && pending) begin
                per_a    <= per_s;
                high_a   <= high_s;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                per_s   <= per_c;
                high_s  <= high_c;
                pending <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_PHASE_OUT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= en ? cnt : '0;
        end
    end
`endif

endmodule
